hygro_monitor: RTL and testbench
================================

HYGRO_MONITOR -- requirements
Module: hygro_monitor

Interface
REQ-001 The block SHALL have parameters: DATA_W, default 14, sample width; PERIOD, default 100_000_000, auto-measure interval in clk cycles (>=2); TIMEOUT, default 10_000_000, max cycles waiting for new_data; AVG_LOG2, default 2, moving-average depth 2^AVG_LOG2 (1..4).
REQ-002 Ports SHALL be: clk  in  1  system clock; rst  in  1  reset, synchronous, active-high.
REQ-003 Request ports SHALL be: manual  in  1  one-cycle measure request; auto_en  in  1  enables periodic measurement; stats_clr  in  1  one-cycle clear of statistics.
REQ-004 Sensor-core ports SHALL be: measure  out  1  one-cycle measure pulse to sensor core; sensor_busy  in  1  core busy; new_data  in  1  one-cycle result-valid pulse; tem_in  in  DATA_W  temperature; hum_in  in  DATA_W  humidity.
REQ-005 Display ports SHALL be: ch_sel  in  1  0 = temperature, 1 = humidity; mode_sel  in  2  00 last, 01 average, 10 min, 11 max; disp  out  DATA_W  selected value; valid  out  1  at least one sample since clear; timeout  out  1  sticky timeout flag; sample_cnt  out  16  samples accepted since clear.

Function
REQ-006 FSM states SHALL be IDLE, TRIG, WAIT, UPD; reset state IDLE.
REQ-007 Interval counter SHALL count 0..PERIOD-1 while auto_en=1, wrap to 0 and set pending flag on terminal count; it SHALL hold at 0 while auto_en=0.
REQ-008 manual=1 SHALL set the pending flag; requests arriving while pending is already set or FSM is not IDLE SHALL merge into one pending request (no queueing beyond one).
REQ-009 IDLE->TRIG when pending=1 and sensor_busy=0; pending SHALL clear on that transition.
REQ-010 TRIG SHALL assert measure for exactly one cycle, then go to WAIT.
REQ-011 WAIT SHALL count cycles; new_data=1 -> UPD with tem_in/hum_in captured that cycle; count reaching TIMEOUT without new_data -> IDLE and timeout set to 1.
REQ-012 UPD (one cycle) SHALL update per channel: last value, ring buffer, running sum, min, max; sample_cnt increments, saturating at 65535; then -> IDLE.
REQ-013 Ring buffer per channel SHALL hold 2^AVG_LOG2 samples; sum width DATA_W+AVG_LOG2; the new sample replaces the oldest, sum += new - oldest.
REQ-014 Average output SHALL be sum >> AVG_LOG2 once the buffer has been filled since the last clear; before that it SHALL equal the last sample.
REQ-015 First sample after clear SHALL set min and max to that sample; later samples update with unsigned compare, ties leave value unchanged.
REQ-016 disp SHALL be a registered mux of ch_sel/mode_sel, reflecting a change one cycle later; disp is 0 while valid=0.
REQ-017 stats_clr SHALL zero buffers, sums, min, max, last, fill count, sample_cnt, valid and timeout in one cycle without changing FSM state or pending.
REQ-018 stats_clr coincident with UPD: clear wins; that sample is discarded entirely.
REQ-019 new_data outside WAIT SHALL be ignored; measure SHALL never assert outside TRIG.

Reset
REQ-020 On rst: FSM IDLE, pending 0, interval and timeout counters 0, measure 0, disp 0, valid 0, timeout 0, sample_cnt 0, all statistics and buffers 0.
REQ-021 rst mid-WAIT SHALL abandon the measurement; a later new_data SHALL be ignored.

Verification (PERIOD=100, TIMEOUT=50, AVG_LOG2=2, DATA_W=14)
REQ-022 manual pulse, core answers new_data with tem_in=0x1000 10 cycles after measure -> one measure pulse, sample_cnt=1, valid=1, disp(ch 0, any mode)=0x1000.
REQ-023 Samples 4,8,12,16 then 20 -> average 4 after first (unfilled), 10 after fourth, 14 after fifth; min 4, max 20.
REQ-024 auto_en=1 with immediate responses over 1000 cycles -> exactly 10 measure pulses, spaced 100 cycles apart.
REQ-025 No new_data after measure -> return to IDLE 50 cycles later, timeout=1, sample_cnt unchanged; next manual pulse yields a new measure pulse.
REQ-026 manual while sensor_busy=1 plus a second manual -> single measure pulse, issued the cycle after busy drops.
REQ-027 stats_clr in the UPD cycle -> sample_cnt=0, valid=0, disp=0; rst during WAIT followed by new_data -> all outputs stay at reset values.

Source files
------------

// File: rtl/hygro_monitor.sv
// hygro_monitor: triggers temperature/humidity measurements on a sensor core
// (manual request or periodic auto-measure), captures results, and keeps
// per-channel statistics (last, moving average, min, max) for display.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   manual              one-cycle measure request
//   auto_en             enables periodic measurement every PERIOD cycles
//   stats_clr           one-cycle clear of all statistics and flags
//   measure             one-cycle measure pulse to the sensor core
//   sensor_busy         sensor core busy, holds off new triggers
//   new_data            one-cycle result-valid pulse from the core
//   tem_in, hum_in      temperature / humidity result
//   ch_sel              display channel: 0 temperature, 1 humidity
//   mode_sel            display mode: 00 last, 01 average, 10 min, 11 max
//   disp                selected statistic (0 while no valid sample)
//   valid               at least one sample accepted since clear
//   timeout             sticky flag: sensor failed to answer within TIMEOUT
//   sample_cnt          samples accepted since clear (saturating)
module hygro_monitor #(
  parameter int unsigned DATA_W   = 14,
  parameter int unsigned PERIOD   = 100_000_000,
  parameter int unsigned TIMEOUT  = 10_000_000,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              manual,
  input  logic              auto_en,
  input  logic              stats_clr,
  output logic              measure,
  input  logic              sensor_busy,
  input  logic              new_data,
  input  logic [DATA_W-1:0] tem_in,
  input  logic [DATA_W-1:0] hum_in,
  input  logic              ch_sel,
  input  logic [1:0]        mode_sel,
  output logic [DATA_W-1:0] disp,
  output logic              valid,
  output logic              timeout,
  output logic [15:0]       sample_cnt
);

  localparam int unsigned DEPTH  = 1 << AVG_LOG2;
  localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
  localparam int unsigned PER_W  = $clog2(PERIOD);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned FILL_W = AVG_LOG2 + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TRIG = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_UPD  = 2'd3;

  // Control state
  logic [1:0]        state_q,    state_d;
  logic              pending_q,  pending_d;
  logic [PER_W-1:0]  per_cnt_q,  per_cnt_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              measure_q,  measure_d;
  logic [DATA_W-1:0] cap_q [2];
  logic [DATA_W-1:0] cap_d [2];
  logic              per_tc;
  logic              take;
  logic              timeout_set;

  // Statistics state (index 0 = temperature, 1 = humidity)
  logic [DATA_W-1:0] buf_q [2][DEPTH];
  logic [DATA_W-1:0] buf_d [2][DEPTH];
  logic [SUM_W-1:0]  sum_q [2];
  logic [SUM_W-1:0]  sum_d [2];
  logic [DATA_W-1:0] last_q [2];
  logic [DATA_W-1:0] last_d [2];
  logic [DATA_W-1:0] min_q [2];
  logic [DATA_W-1:0] min_d [2];
  logic [DATA_W-1:0] max_q [2];
  logic [DATA_W-1:0] max_d [2];
  logic [AVG_LOG2-1:0] ptr_q,  ptr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [15:0]       sample_cnt_q, sample_cnt_d;
  logic              valid_q,   valid_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] disp_q,    disp_d;
  logic [DATA_W-1:0] avg_sel;

  // Interval counter, request merging and measurement FSM
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    per_cnt_d   = per_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    cap_d       = cap_q;
    per_tc      = 1'b0;
    timeout_set = 1'b0;

    if (!auto_en) begin
      per_cnt_d = '0;
    end else if (per_cnt_q == PER_W'(PERIOD - 1)) begin
      per_cnt_d = '0;
      per_tc    = 1'b1;
    end else begin
      per_cnt_d = per_cnt_q + PER_W'(1);
    end

    case (state_q)
      S_IDLE: if (pending_q && !sensor_busy) state_d = S_TRIG;
      S_TRIG: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (new_data) begin
          state_d  = S_UPD;
          cap_d[0] = tem_in;
          cap_d[1] = hum_in;
        end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      S_UPD:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A request coinciding with the trigger merges into the one being issued
    take = (state_q == S_IDLE) && pending_q && !sensor_busy;
    if (take)                  pending_d = 1'b0;
    else if (manual || per_tc) pending_d = 1'b1;

    measure_d = (state_d == S_TRIG);
  end

  // Statistics update; a clear overrides any update in the same cycle
  always_comb begin
    buf_d        = buf_q;
    sum_d        = sum_q;
    last_d       = last_q;
    min_d        = min_q;
    max_d        = max_q;
    ptr_d        = ptr_q;
    fill_d       = fill_q;
    sample_cnt_d = sample_cnt_q;
    valid_d      = valid_q;
    timeout_d    = timeout_q;

    if (stats_clr) begin
      buf_d        = '{default: '0};
      sum_d        = '{default: '0};
      last_d       = '{default: '0};
      min_d        = '{default: '0};
      max_d        = '{default: '0};
      ptr_d        = '0;
      fill_d       = '0;
      sample_cnt_d = '0;
      valid_d      = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      if (timeout_set) timeout_d = 1'b1;
      if (state_q == S_UPD) begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
          // Buffer starts zeroed, so the running sum stays exact while filling
          sum_d[1'(ch)] = sum_q[1'(ch)] + SUM_W'(cap_q[1'(ch)])
                          - SUM_W'(buf_q[1'(ch)][ptr_q]);
          buf_d[1'(ch)][ptr_q] = cap_q[1'(ch)];
          last_d[1'(ch)]       = cap_q[1'(ch)];
          if (!valid_q) begin
            min_d[1'(ch)] = cap_q[1'(ch)];
            max_d[1'(ch)] = cap_q[1'(ch)];
          end else begin
            if (cap_q[1'(ch)] < min_q[1'(ch)]) min_d[1'(ch)] = cap_q[1'(ch)];
            if (cap_q[1'(ch)] > max_q[1'(ch)]) max_d[1'(ch)] = cap_q[1'(ch)];
          end
        end
        ptr_d = ptr_q + AVG_LOG2'(1);
        if (fill_q != FILL_W'(DEPTH))  fill_d       = fill_q + FILL_W'(1);
        if (sample_cnt_q != 16'hFFFF)  sample_cnt_d = sample_cnt_q + 16'd1;
        valid_d = 1'b1;
      end
    end

    // Display mux built from next-state statistics so it tracks updates
    avg_sel = (fill_d == FILL_W'(DEPTH)) ? DATA_W'(sum_d[ch_sel] >> AVG_LOG2)
                                         : last_d[ch_sel];
    case (mode_sel)
      2'b00:   disp_d = last_d[ch_sel];
      2'b01:   disp_d = avg_sel;
      2'b10:   disp_d = min_d[ch_sel];
      default: disp_d = max_d[ch_sel];
    endcase
    if (!valid_d) disp_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      per_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      measure_q    <= 1'b0;
      cap_q        <= '{default: '0};
      buf_q        <= '{default: '0};
      sum_q        <= '{default: '0};
      last_q       <= '{default: '0};
      min_q        <= '{default: '0};
      max_q        <= '{default: '0};
      ptr_q        <= '0;
      fill_q       <= '0;
      sample_cnt_q <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      disp_q       <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      per_cnt_q    <= per_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      measure_q    <= measure_d;
      cap_q        <= cap_d;
      buf_q        <= buf_d;
      sum_q        <= sum_d;
      last_q       <= last_d;
      min_q        <= min_d;
      max_q        <= max_d;
      ptr_q        <= ptr_d;
      fill_q       <= fill_d;
      sample_cnt_q <= sample_cnt_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      disp_q       <= disp_d;
    end
  end

  assign measure    = measure_q;
  assign disp       = disp_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_hygro_monitor.sv
// Testbench for hygro_monitor: randomized samples checked against a
// queue-based model of the statistics (last, average of last 4, min, max).
module tb_hygro_monitor;

  localparam int unsigned DATA_W   = 14;
  localparam int unsigned PERIOD   = 100;
  localparam int unsigned TIMEOUT  = 50;
  localparam int unsigned AVG_LOG2 = 2;

  logic              clk = 1'b0;
  logic              rst, manual, auto_en, stats_clr;
  logic              measure, sensor_busy, new_data;
  logic [DATA_W-1:0] tem_in, hum_in;
  logic              ch_sel;
  logic [1:0]        mode_sel;
  logic [DATA_W-1:0] disp;
  logic              valid, timeout;
  logic [15:0]       sample_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int meas_cnt = 0;

  // Reference model: every sample since the last clear, per channel
  int unsigned tq[$];
  int unsigned hq[$];

  hygro_monitor #(
    .DATA_W(DATA_W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .manual(manual), .auto_en(auto_en),
    .stats_clr(stats_clr), .measure(measure), .sensor_busy(sensor_busy),
    .new_data(new_data), .tem_in(tem_in), .hum_in(hum_in),
    .ch_sel(ch_sel), .mode_sel(mode_sel), .disp(disp), .valid(valid),
    .timeout(timeout), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (measure) meas_cnt++;

  function automatic logic [DATA_W-1:0] exp_disp(int ch, int mode);
    int unsigned q[$];
    int unsigned v, s, n;
    if (ch == 0) q = tq; else q = hq;
    n = q.size();
    if (n == 0) return '0;
    v = q[n-1];
    case (mode)
      1: if (n >= 4) begin
           s = q[n-1] + q[n-2] + q[n-3] + q[n-4];
           v = s / 4;
         end
      2: foreach (q[i]) if (q[i] < v) v = q[i];
      3: foreach (q[i]) if (q[i] > v) v = q[i];
      default: ;
    endcase
    return DATA_W'(v);
  endfunction

  function automatic int unsigned exp_cnt();
    return (tq.size() > 65535) ? 65535 : tq.size();
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_manual();
    manual = 1'b1;
    tick(1);
    manual = 1'b0;
  endtask

  task automatic wait_measure(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (measure) ok = 1'b1;
    end
  endtask

  // Answer a measurement d cycles after the measure pulse was seen
  task automatic send_data(int d, logic [DATA_W-1:0] t, logic [DATA_W-1:0] h);
    repeat (d) @(posedge clk);
    #1;
    new_data = 1'b1;
    tem_in   = t;
    hum_in   = h;
    tick(1);
    new_data = 1'b0;
    tem_in   = DATA_W'($urandom);
    hum_in   = DATA_W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_checks++; if (measure !== 1'b0) begin n_fail++; $display("FAIL reset measure: got %b want 0", measure); end
    n_checks++; if (disp !== '0) begin n_fail++; $display("FAIL reset disp: got %h want 0", disp); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", valid); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset timeout: got %b want 0", timeout); end
    n_checks++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL reset sample_cnt: got %0d want 0", sample_cnt); end
  endtask

  task automatic test_manual();
    bit ok;
    int c0;
    logic [DATA_W-1:0] h;
    c0 = meas_cnt;
    h  = DATA_W'($urandom);
    pulse_manual();
    wait_measure(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL manual measure: no pulse within bound"); end
    @(negedge clk);
    n_checks++; if (measure !== 1'b0) begin n_fail++; $display("FAIL manual measure width: got %b want 0 on 2nd cycle", measure); end
    send_data(9, 14'h1000, h);
    tq.push_back(32'h1000); hq.push_back(h);
    tick(3);
    n_checks++; if (meas_cnt - c0 != 1) begin n_fail++; $display("FAIL manual pulse count: got %0d want 1", meas_cnt - c0); end
    n_checks++; if (sample_cnt !== 16'(exp_cnt())) begin n_fail++; $display("FAIL manual sample_cnt: got %0d want %0d", sample_cnt, exp_cnt()); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL manual valid: got %b want 1", valid); end
    for (int m = 0; m < 4; m++) begin
      ch_sel = 1'b0; mode_sel = 2'(m);
      tick(2);
      n_checks++; if (disp !== 14'h1000) begin n_fail++; $display("FAIL manual disp mode%0d: got %h want 1000", m, disp); end
    end
  endtask

  task automatic test_average();
    bit ok;
    int unsigned vals[5] = '{4, 8, 12, 16, 20};
    stats_clr = 1'b1; tick(1); stats_clr = 1'b0;
    tq.delete(); hq.delete();
    for (int k = 0; k < 5; k++) begin
      logic [DATA_W-1:0] h;
      h = DATA_W'($urandom);
      tick(1);
      pulse_manual();
      wait_measure(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL average measure %0d: no pulse", k); end
      send_data(1 + k, DATA_W'(vals[k]), h);
      tq.push_back(vals[k]); hq.push_back(h);
      ch_sel = 1'b0; mode_sel = 2'b01;
      tick(3);
      n_checks++; if (disp !== exp_disp(0, 1)) begin n_fail++; $display("FAIL average after sample %0d: got %0d want %0d", k, disp, exp_disp(0, 1)); end
    end
    mode_sel = 2'b10; tick(2);
    n_checks++; if (disp !== exp_disp(0, 2)) begin n_fail++; $display("FAIL average min: got %0d want %0d", disp, exp_disp(0, 2)); end
    mode_sel = 2'b11; tick(2);
    n_checks++; if (disp !== exp_disp(0, 3)) begin n_fail++; $display("FAIL average max: got %0d want %0d", disp, exp_disp(0, 3)); end
  endtask

  task automatic test_random();
    bit ok;
    for (int k = 0; k < 12; k++) begin
      logic [DATA_W-1:0] t, h;
      t = DATA_W'($urandom);
      h = DATA_W'($urandom);
      if (k == 5) t = DATA_W'(tq[tq.size()-1]);
      pulse_manual();
      wait_measure(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL random measure %0d: no pulse", k); end
      send_data(int'($urandom_range(1, 40)), t, h);
      tq.push_back(t); hq.push_back(h);
      tick(3);
      n_checks++; if (sample_cnt !== 16'(exp_cnt())) begin n_fail++; $display("FAIL random sample_cnt %0d: got %0d want %0d", k, sample_cnt, exp_cnt()); end
      for (int ch = 0; ch < 2; ch++) begin
        for (int m = 0; m < 4; m++) begin
          ch_sel = 1'(ch); mode_sel = 2'(m);
          tick(2);
          n_checks++; if (disp !== exp_disp(ch, m)) begin n_fail++; $display("FAIL random disp s%0d ch%0d mode%0d: got %h want %h", k, ch, m, disp, exp_disp(ch, m)); end
        end
      end
    end
  endtask

  task automatic test_auto();
    int times[$];
    bit saw;
    int c0;
    saw = 1'b0;
    auto_en = 1'b1;
    for (int c = 0; c < 1010; c++) begin
      @(negedge clk);
      if (measure) begin times.push_back(c); saw = 1'b1; end
      @(posedge clk); #1;
      if (saw) begin
        logic [DATA_W-1:0] t, h;
        t = DATA_W'($urandom); h = DATA_W'($urandom);
        new_data = 1'b1; tem_in = t; hum_in = h;
        tq.push_back(t); hq.push_back(h);
      end else begin
        new_data = 1'b0;
      end
      saw = 1'b0;
    end
    new_data = 1'b0;
    auto_en  = 1'b0;
    c0 = meas_cnt;
    tick(250);
    n_checks++; if (times.size() != 10) begin n_fail++; $display("FAIL auto pulse count: got %0d want 10", times.size()); end
    for (int i = 1; i < times.size(); i++) begin
      n_checks++; if (times[i] - times[i-1] != int'(PERIOD)) begin n_fail++; $display("FAIL auto spacing %0d: got %0d want %0d", i, times[i] - times[i-1], PERIOD); end
    end
    n_checks++; if (meas_cnt != c0) begin n_fail++; $display("FAIL auto disabled pulses: got %0d want 0", meas_cnt - c0); end
    n_checks++; if (sample_cnt !== 16'(exp_cnt())) begin n_fail++; $display("FAIL auto sample_cnt: got %0d want %0d", sample_cnt, exp_cnt()); end
    ch_sel = 1'b1; mode_sel = 2'b01; tick(2);
    n_checks++; if (disp !== exp_disp(1, 1)) begin n_fail++; $display("FAIL auto hum average: got %h want %h", disp, exp_disp(1, 1)); end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [DATA_W-1:0] t, h;
    pulse_manual();
    wait_measure(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout measure: no pulse"); end
    repeat (TIMEOUT - 1) @(negedge clk);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout early: got %b want 0", timeout); end
    repeat (2) @(negedge clk);
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout flag: got %b want 1", timeout); end
    n_checks++; if (sample_cnt !== 16'(exp_cnt())) begin n_fail++; $display("FAIL timeout sample_cnt: got %0d want %0d", sample_cnt, exp_cnt()); end
    tick(1);
    t = DATA_W'($urandom); h = DATA_W'($urandom);
    pulse_manual();
    wait_measure(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout retry: no measure pulse"); end
    send_data(3, t, h);
    tq.push_back(t); hq.push_back(h);
    tick(3);
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout sticky: got %b want 1", timeout); end
    n_checks++; if (sample_cnt !== 16'(exp_cnt())) begin n_fail++; $display("FAIL timeout retry sample_cnt: got %0d want %0d", sample_cnt, exp_cnt()); end
  endtask

  task automatic test_busy();
    int c0;
    c0 = meas_cnt;
    sensor_busy = 1'b1;
    pulse_manual();
    tick(3);
    pulse_manual();
    tick(5);
    n_checks++; if (meas_cnt != c0) begin n_fail++; $display("FAIL busy held: got %0d pulses want 0", meas_cnt - c0); end
    sensor_busy = 1'b0;
    @(negedge clk);
    n_checks++; if (measure !== 1'b0) begin n_fail++; $display("FAIL busy early measure: got %b want 0", measure); end
    @(negedge clk);
    n_checks++; if (measure !== 1'b1) begin n_fail++; $display("FAIL busy measure after drop: got %b want 1", measure); end
    begin
      logic [DATA_W-1:0] t, h;
      t = DATA_W'($urandom); h = DATA_W'($urandom);
      send_data(2, t, h);
      tq.push_back(t); hq.push_back(h);
    end
    tick(20);
    n_checks++; if (meas_cnt - c0 != 1) begin n_fail++; $display("FAIL busy pulse count: got %0d want 1", meas_cnt - c0); end
    n_checks++; if (sample_cnt !== 16'(exp_cnt())) begin n_fail++; $display("FAIL busy sample_cnt: got %0d want %0d", sample_cnt, exp_cnt()); end
  endtask

  task automatic test_clr_upd();
    bit ok;
    logic [DATA_W-1:0] t;
    pulse_manual();
    wait_measure(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clr measure: no pulse"); end
    @(posedge clk); #1;
    new_data = 1'b1; tem_in = DATA_W'($urandom); hum_in = DATA_W'($urandom);
    tick(1);
    new_data  = 1'b0;
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
    tq.delete(); hq.delete();
    ch_sel = 1'b0; mode_sel = 2'b00;
    tick(2);
    n_checks++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL clr sample_cnt: got %0d want 0", sample_cnt); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL clr valid: got %b want 0", valid); end
    n_checks++; if (disp !== '0) begin n_fail++; $display("FAIL clr disp: got %h want 0", disp); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL clr timeout: got %b want 0", timeout); end
    t = DATA_W'($urandom);
    pulse_manual();
    wait_measure(ok);
    send_data(2, t, t);
    tq.push_back(t); hq.push_back(t);
    mode_sel = 2'b10; tick(3);
    n_checks++; if (disp !== exp_disp(0, 2)) begin n_fail++; $display("FAIL clr first min: got %h want %h", disp, exp_disp(0, 2)); end
    mode_sel = 2'b11; tick(2);
    n_checks++; if (disp !== exp_disp(0, 3)) begin n_fail++; $display("FAIL clr first max: got %h want %h", disp, exp_disp(0, 3)); end
  endtask

  task automatic test_reset_wait();
    bit ok;
    int c0;
    pulse_manual();
    wait_measure(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstwait measure: no pulse"); end
    tick(5);
    rst = 1'b1; tick(1); rst = 1'b0;
    tq.delete(); hq.delete();
    c0 = meas_cnt;
    new_data = 1'b1; tem_in = DATA_W'($urandom); hum_in = DATA_W'($urandom);
    tick(1);
    new_data = 1'b0;
    tick(TIMEOUT + 10);
    n_checks++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL rstwait sample_cnt: got %0d want 0", sample_cnt); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstwait valid: got %b want 0", valid); end
    n_checks++; if (disp !== '0) begin n_fail++; $display("FAIL rstwait disp: got %h want 0", disp); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rstwait timeout: got %b want 0", timeout); end
    n_checks++; if (meas_cnt != c0) begin n_fail++; $display("FAIL rstwait measure: got %0d pulses want 0", meas_cnt - c0); end
    new_data = 1'b1; tick(1); new_data = 1'b0;
    tick(3);
    n_checks++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL stray new_data: got %0d want 0", sample_cnt); end
  endtask

  initial begin
    rst = 1'b1; manual = 1'b0; auto_en = 1'b0; stats_clr = 1'b0;
    sensor_busy = 1'b0; new_data = 1'b0; tem_in = '0; hum_in = '0;
    ch_sel = 1'b0; mode_sel = 2'b00;
    test_reset();
    test_manual();
    test_average();
    test_random();
    test_auto();
    test_timeout();
    test_busy();
    test_clr_upd();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
